// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch front-end: credit-limited sequential fetch, in-order
// response capture into a prefetch FIFO, and redirect with stale-response dropping.
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int             PTR_W      = $clog2(FIFO_DEPTH);
    localparam int             CNT_W      = PTR_W + 1;
    localparam logic [CNT_W:0] CREDIT_CAP = (CNT_W + 1)'(FIFO_DEPTH);

    logic             run_q;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      fifo_instr_q [FIFO_DEPTH];
    logic [31:0]      fifo_pc_q    [FIFO_DEPTH];

    logic        req_fire;
    logic        rsp_fire;
    logic        pop;
    logic        fifo_wr;
    logic [31:0] redirect_target;

    // Requests in flight plus buffered entries never exceed the FIFO size.
    assign imem_req_valid = run_q && (({1'b0, outstanding_q} + {1'b0, count_q}) < CREDIT_CAP);
    assign imem_req_addr  = fetch_pc_q;
    assign out_valid      = (count_q != '0);
    assign out_instr      = out_valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign out_pc         = out_valid ? fifo_pc_q[rd_ptr_q] : '0;

    always_comb begin
        req_fire        = imem_req_valid && imem_req_ready;
        rsp_fire        = imem_rsp_valid && (outstanding_q != '0);
        pop             = out_valid && out_ready;
        redirect_target = redirect_pc & 32'hFFFF_FFFC;
        fifo_wr         = rsp_fire && !redirect_valid && (drop_q == '0);

        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
        fetch_pc_d    = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        rsp_pc_d      = fifo_wr ? rsp_pc_q + 32'd4 : rsp_pc_q;
        wr_ptr_d      = fifo_wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d       = count_q + CNT_W'(fifo_wr) - CNT_W'(pop);
        drop_d        = (rsp_fire && (drop_q != '0)) ? drop_q - CNT_W'(1) : drop_q;

        // Everything still in flight after this edge belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            rsp_pc_d   = redirect_target;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            drop_d     = outstanding_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q         <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            run_q         <= 1'b1;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage needs no reset: reads are gated by count_q.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
            fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Bench for rv32i_fetch_unit: directed vector table, hand-written corner sequences,
// and randomized traffic against an epoch-tagged reference model.
module tb_rv32i_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } inflight_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        bit          reqReady;
        bit          outReady;
        bit          redir;
        logic [31:0] redirPc;
        bit          expReqValid;
        logic [31:0] expReqAddr;
        bit          expOutValid;
        logic [31:0] expOutPc;
    } vec_t;

    logic        clk, rst;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        out_valid, out_ready, redirect_valid;
    logic [31:0] imem_req_addr, imem_rsp_data, out_instr, out_pc, redirect_pc;

    int          cyc, lat, lastDue, assertCount, failCount;
    memReq_t     pending[$];
    inflight_t   inflight[$];
    entry_t      fifo[$];
    bit          mRun;
    logic [31:0] mPc;
    int          epoch;
    vec_t        vecs[16];

    rv32i_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'h1000 + {2'b00, a[31:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s @cycle %0d: got 0x%08h, want 0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        inflight.delete();
        fifo.delete();
        mRun  = 1'b0;
        mPc   = RESET_PC;
        epoch = 0;
    endtask

    task automatic applyStimulus(input bit rr, input bit oR, input bit rv, input logic [31:0] rpc);
        imem_req_ready = rr;
        out_ready      = oR;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic checkOutput();
        bit expRv;
        expRv = mRun && ((inflight.size() + fifo.size()) < DEPTH);
        check("req_valid", imem_req_valid, expRv);
        check("req_addr", imem_req_addr, mPc);
        check("out_valid", out_valid, fifo.size() > 0);
        if (fifo.size() > 0) begin
            check("out_pc", out_pc, fifo[0].pc);
            check("out_instr", out_instr, fifo[0].instr);
        end
    endtask

    task automatic checkReset();
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
    endtask

    // Advance the model and the memory across one rising edge.
    task automatic stepCycle();
        inflight_t t;
        entry_t    e;
        memReq_t   m;
        bit        mReqFire, mRsp, mPop;
        mReqFire = mRun && ((inflight.size() + fifo.size()) < DEPTH) && imem_req_ready;
        mRsp     = imem_rsp_valid && (inflight.size() > 0);
        mPop     = (fifo.size() > 0) && out_ready;
        if (rst) begin
            modelReset();
        end else begin
            if (mPop) void'(fifo.pop_front());
            if (mRsp) begin
                t = inflight.pop_front();
                if (!redirect_valid && t.epoch == epoch) begin
                    e.pc    = t.addr;
                    e.instr = imem_rsp_data;
                    fifo.push_back(e);
                end
            end
            if (mReqFire) begin
                t.addr  = mPc;
                t.epoch = epoch;
                inflight.push_back(t);
                mPc = mPc + 32'd4;
            end
            if (redirect_valid) begin
                epoch++;
                mPc = {redirect_pc[31:2], 2'b00};
                fifo.delete();
            end
            mRun = 1'b1;
        end
        if (imem_req_valid && imem_req_ready) begin
            m.addr = imem_req_addr;
            m.due  = cyc + lat;
            if (m.due <= lastDue) m.due = lastDue + 1;
            lastDue = m.due;
            pending.push_back(m);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(pending[0].addr);
            void'(pending.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        modelReset();
        pending.delete();
        imem_rsp_valid = 1'b0;
        #1;
        for (int i = 0; i < n; i++) begin
            checkReset();
            stepCycle();
        end
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] expPc;
        bit          seen;
        int          hsCount;
        assertCount = 0;
        failCount   = 0;
        cyc         = 0;
        lat         = 1;
        lastDue     = 0;
        rst         = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        modelReset();

        // One row per cycle from reset release; 1-cycle memory, always ready.
        vecs[0]  = '{1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0};
        vecs[1]  = '{1, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0};
        vecs[2]  = '{1, 0, 0, 32'h0,         1, 32'h4,         0, 32'h0};
        vecs[3]  = '{1, 0, 0, 32'h0,         1, 32'h8,         1, 32'h0};
        vecs[4]  = '{1, 0, 0, 32'h0,         1, 32'hC,         1, 32'h0};
        vecs[5]  = '{1, 0, 0, 32'h0,         0, 32'h10,        1, 32'h0};
        vecs[6]  = '{1, 1, 0, 32'h0,         0, 32'h10,        1, 32'h0};
        vecs[7]  = '{1, 1, 0, 32'h0,         1, 32'h10,        1, 32'h4};
        vecs[8]  = '{1, 1, 1, 32'h103,       1, 32'h14,        1, 32'h8};
        vecs[9]  = '{1, 1, 0, 32'h0,         1, 32'h100,       0, 32'h0};
        vecs[10] = '{1, 1, 0, 32'h0,         1, 32'h104,       0, 32'h0};
        vecs[11] = '{1, 1, 1, 32'hFFFF_FFFC, 1, 32'h108,       1, 32'h100};
        vecs[12] = '{1, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0};
        vecs[13] = '{1, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0};
        vecs[14] = '{1, 1, 0, 32'h0,         1, 32'h4,         1, 32'hFFFF_FFFC};
        vecs[15] = '{1, 1, 0, 32'h0,         1, 32'h8,         1, 32'h0};

        $display("[TB] reset, backpressure, misaligned redirect and wrap table");
        doReset(3);
        lat = 1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].reqReady, vecs[i].outReady, vecs[i].redir, vecs[i].redirPc);
            checkOutput();
            check($sformatf("tbl%0d_req_valid", i), imem_req_valid, vecs[i].expReqValid);
            check($sformatf("tbl%0d_req_addr", i), imem_req_addr, vecs[i].expReqAddr);
            check($sformatf("tbl%0d_out_valid", i), out_valid, vecs[i].expOutValid);
            if (vecs[i].expOutValid) begin
                check($sformatf("tbl%0d_out_pc", i), out_pc, vecs[i].expOutPc);
                check($sformatf("tbl%0d_out_instr", i), out_instr, memWord(vecs[i].expOutPc));
            end
            stepCycle();
        end

        $display("[TB] streaming with 1-cycle memory");
        doReset(2);
        lat   = 1;
        expPc = 32'h0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput();
            if (i >= 3) check("stream_no_gap", out_valid, 1'b1);
            if (out_valid) begin
                check("stream_pc", out_pc, expPc);
                check("stream_instr", out_instr, memWord(expPc));
                expPc = expPc + 32'd4;
            end
            stepCycle();
        end
        check("stream_total", expPc, 32'h44);

        $display("[TB] redirect with two responses in flight, 3-cycle memory");
        doReset(2);
        lat = 3;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput();
            stepCycle();
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
        checkOutput();
        stepCycle();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput();
            if (out_valid && !seen) begin
                check("redir_first_pc", out_pc, 32'h100);
                check("redir_first_instr", out_instr, 32'h1040);
                seen = 1'b1;
            end
            stepCycle();
        end
        check("redir_first_seen", seen, 1'b1);

        $display("[TB] asynchronous reset mid-operation");
        doReset(2);
        lat = 3;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            checkOutput();
            stepCycle();
        end
        check("midrst_pre_out_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_req_valid", imem_req_valid, 1'b0);
        modelReset();
        stepCycle();
        rst = 1'b0;
        checkOutput();
        stepCycle();
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput();
            if (out_valid && !seen) begin
                check("midrst_first_pc", out_pc, RESET_PC);
                check("midrst_first_instr", out_instr, memWord(RESET_PC));
                seen = 1'b1;
            end
            stepCycle();
        end
        check("midrst_restart_seen", seen, 1'b1);

        $display("[TB] randomized traffic against reference model");
        doReset(2);
        hsCount = 0;
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rpc;
            bit          rv;
            lat = int'($urandom_range(1, 4));
            rv  = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                default: rpc = $urandom_range(0, 255);
            endcase
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rv, rpc);
            checkOutput();
            if (out_valid && out_ready) hsCount++;
            stepCycle();
        end
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput();
            stepCycle();
        end
        check("random_progress", hsCount > 100, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
